// File: rtl/fetch_unit_mo.sv
// Instruction-fetch stage: issues in-order fetches on an SRAM-like bus, tracks in-flight
// requests, drops stale responses after redirects and queues instructions toward decode.
module fetch_unit_mo #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IBUF_DEPTH      = 4,
  parameter int          BR_BUS_WD       = 33,
  parameter int          FS_TO_DS_BUS_WD = 65
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  input  logic                       fs_flush_pipe,
  input  logic [31:0]                ws_to_fs_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_req,
  output logic                       inst_sram_wr,
  output logic [3:0]                 inst_sram_wstrb,
  output logic [31:0]                inst_sram_wdata,
  output logic [1:0]                 inst_sram_size,
  output logic [31:0]                inst_sram_addr,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);

  // Handshakes: a request transfers on a cycle with req && addr_ok, and req/addr hold until
  // then; data_ok returns one response per cycle in request order; decode takes the head
  // entry on a cycle with fs_to_ds_valid && ds_allowin.

  localparam int IW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [7:0]    MAX_O   = 8'(MAX_OUTSTANDING);
  localparam logic [7:0]    DEPTH_C = 8'(IBUF_DEPTH);
  localparam logic [PW-1:0] PQ_LAST = PW'(MAX_OUTSTANDING - 1);

  logic        br_taken;
  logic [31:0] br_target;

  logic [31:0] pc;
  logic        req_q;
  logic        pend_v;
  logic        pend_flush;
  logic [31:0] pend_pc;
  logic [7:0]  inflight;
  logic [7:0]  discard_cnt;
  logic [7:0]  ibuf_cnt;
  logic        adef_stall;

  logic [FS_TO_DS_BUS_WD-1:0] ibuf_mem [IBUF_DEPTH];
  logic [IW-1:0]              ib_rd;
  logic [IW-1:0]              ib_wr;
  logic [31:0]                pq_mem [MAX_OUTSTANDING];
  logic [PW-1:0]              pq_rd;
  logic [PW-1:0]              pq_wr;

  logic                       redirect;
  logic [31:0]                redirect_pc;
  logic                       acc;
  logic                       hold;
  logic                       keep;
  logic                       adef_push;
  logic                       push;
  logic                       pop;
  logic [FS_TO_DS_BUS_WD-1:0] push_entry;
  logic [7:0]                 inflight_nx;
  logic [7:0]                 ibuf_cnt_nx;
  logic [7:0]                 discard_nx;
  logic                       adef_stall_nx;
  logic [31:0]                pc_nx;
  logic                       req_nx;
  logic                       pend_write;

  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  assign inst_sram_req   = req_q;
  assign inst_sram_addr  = pc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_size  = 2'h2;

  assign fs_to_ds_valid = (ibuf_cnt != 8'd0) & ~fs_flush_pipe;
  assign fs_to_ds_bus   = ibuf_mem[ib_rd];

  always_comb begin
    redirect    = fs_flush_pipe | br_taken;
    redirect_pc = fs_flush_pipe ? ws_to_fs_bus : br_target;
    acc         = req_q & inst_sram_addr_ok;
    hold        = req_q & ~inst_sram_addr_ok;

    // Responses owed to a pre-redirect path are the oldest ones, so a counter suffices.
    keep      = inst_sram_data_ok & (discard_cnt == 8'd0) & ~redirect;
    adef_push = (pc[1:0] != 2'b00) & ~req_q & ~adef_stall & (inflight == 8'd0) &
                (discard_cnt == 8'd0) & (ibuf_cnt < DEPTH_C) & ~redirect;
    push      = keep | adef_push;
    pop       = fs_to_ds_valid & ds_allowin & ~redirect;

    push_entry = adef_push ? FS_TO_DS_BUS_WD'({1'b1, 32'h0, pc})
                           : FS_TO_DS_BUS_WD'({1'b0, inst_sram_rdata, pq_mem[pq_rd]});

    inflight_nx = inflight + 8'(acc) - 8'(inst_sram_data_ok);
    ibuf_cnt_nx = redirect ? 8'd0 : (ibuf_cnt + 8'(push) - 8'(pop));

    if (redirect)
      discard_nx = inflight_nx + 8'(hold);
    else if (inst_sram_data_ok && (discard_cnt != 8'd0))
      discard_nx = discard_cnt - 8'd1;
    else
      discard_nx = discard_cnt;

    adef_stall_nx = ~redirect & (adef_stall | adef_push);

    // A held request keeps its address; the redirect waits in the pending slot.
    pend_write = hold & redirect & (fs_flush_pipe | ~pend_v | ~pend_flush);

    if (redirect && !hold)
      pc_nx = redirect_pc;
    else if (acc)
      pc_nx = pend_v ? pend_pc : pc + 32'd4;
    else
      pc_nx = pc;

    req_nx = hold |
             ((pc_nx[1:0] == 2'b00) & ~adef_stall_nx & (inflight_nx < MAX_O) &
              ((inflight_nx + ibuf_cnt_nx) < DEPTH_C));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc          <= RESET_PC;
      req_q       <= 1'b0;
      pend_v      <= 1'b0;
      pend_flush  <= 1'b0;
      pend_pc     <= 32'h0;
      inflight    <= 8'd0;
      discard_cnt <= 8'd0;
      ibuf_cnt    <= 8'd0;
      adef_stall  <= 1'b0;
      ib_rd       <= '0;
      ib_wr       <= '0;
      pq_rd       <= '0;
      pq_wr       <= '0;
      for (int i = 0; i < IBUF_DEPTH; i++) ibuf_mem[i] <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) pq_mem[i] <= 32'h0;
    end else begin
      pc          <= pc_nx;
      req_q       <= req_nx;
      inflight    <= inflight_nx;
      discard_cnt <= discard_nx;
      ibuf_cnt    <= ibuf_cnt_nx;
      adef_stall  <= adef_stall_nx;

      if (pend_write) begin
        pend_v     <= 1'b1;
        pend_flush <= fs_flush_pipe;
        pend_pc    <= redirect_pc;
      end else if (!hold) begin
        pend_v <= 1'b0;
      end

      if (acc) begin
        pq_mem[pq_wr] <= pc;
        pq_wr         <= (pq_wr == PQ_LAST) ? '0 : pq_wr + PW'(1);
      end
      if (inst_sram_data_ok)
        pq_rd <= (pq_rd == PQ_LAST) ? '0 : pq_rd + PW'(1);

      if (redirect) begin
        ib_rd <= '0;
        ib_wr <= '0;
      end else begin
        if (push) begin
          ibuf_mem[ib_wr] <= push_entry;
          ib_wr           <= ib_wr + IW'(1);
        end
        if (pop)
          ib_rd <= ib_rd + IW'(1);
      end
    end
  end

endmodule
